// File: rtl/memory_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package memory_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } stateT;

    localparam int unsigned WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'(WORD_BYTES - 1);

    // Misaligned or beyond the last word of a DEPTH-word array.
    function automatic logic isBadAddr(input logic [31:0] addr, input int unsigned depth);
        return ((addr & ADDR_ALIGN_MASK) != 32'h0) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/memory_array.sv
// Word storage with combinational read and byte-enabled synchronous write; not reset.
module memory_array
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] byteEn,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: accepts one request, inserts WAIT_CYCLES wait
// states, then presents a response held until the processor accepts it.
module memory_responder
    import memory_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    input  logic [3:0]  reqByteEn,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRdata,
    output logic        rspError
);

    localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    stateT       stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic        writeQ;
    logic [31:0] addrQ, wdataQ;
    logic [3:0]  byteEnQ;
    logic [31:0] rdataQ;
    logic        errorQ;

    logic        accept, enterResp;
    logic        curWrite, curError;
    logic [31:0] curAddr, curWdata;
    logic [3:0]  curByteEn;
    logic [31:0] memRdata;
    logic        memWe;

    // Gated by rst_n so the handshake stays closed while reset is held.
    assign reqReady = rst_n && (stateQ == StIdle);
    assign rspValid = (stateQ == StResp);
    assign rspRdata = rdataQ;
    assign rspError = errorQ;
    assign accept   = reqValid && reqReady;

    // With zero wait states RESP is entered on the acceptance edge, before the latches load.
    always_comb begin
        curWrite  = writeQ;
        curAddr   = addrQ;
        curWdata  = wdataQ;
        curByteEn = byteEnQ;
        if (stateQ == StIdle) begin
            curWrite  = reqWrite;
            curAddr   = reqAddr;
            curWdata  = reqWdata;
            curByteEn = reqByteEn;
        end
        curError = isBadAddr(curAddr, DEPTH);
        memWe    = enterResp && curWrite && !curError;
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        enterResp = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        stateD = StWait;
                        cntD   = WAIT_LOAD;
                    end else begin
                        stateD    = StResp;
                        enterResp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cntQ == 4'd0) begin
                    stateD    = StResp;
                    enterResp = 1'b1;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            StResp: begin
                if (rspReady) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeQ  <= 1'b0;
            addrQ   <= 32'h0;
            wdataQ  <= 32'h0;
            byteEnQ <= 4'h0;
        end else if (accept) begin
            writeQ  <= reqWrite;
            addrQ   <= reqAddr;
            wdataQ  <= reqWdata;
            byteEnQ <= reqByteEn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdataQ <= 32'h0;
            errorQ <= 1'b0;
        end else if (enterResp) begin
            rdataQ <= (curWrite || curError) ? 32'h0 : memRdata;
            errorQ <= curError;
        end
    end

    memory_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk     (clk),
        .writeEn (memWe),
        .addr    (curAddr[ADDR_W+1:2]),
        .wdata   (curWdata),
        .byteEn  (curByteEn),
        .rdata   (memRdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: one instance with two wait states, one with none.
module tb_memory_responder;

    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        reqValid, reqReady, reqWrite, rspValid, rspReady, rspError;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [3:0]  reqByteEn;

    logic        zReqValid, zReqReady, zReqWrite, zRspValid, zRspReady, zRspError;
    logic [31:0] zReqAddr, zReqWdata, zRspRdata;
    logic [3:0]  zReqByteEn;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    expT sb[$];
    logic [31:0] model [int];

    always @(posedge clk) cyc <= cyc + 1;

    memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqAddr(reqAddr),
        .reqWdata(reqWdata), .reqByteEn(reqByteEn),
        .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspError(rspError)
    );

    memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .reqValid(zReqValid), .reqReady(zReqReady), .reqWrite(zReqWrite), .reqAddr(zReqAddr),
        .reqWdata(zReqWdata), .reqByteEn(zReqByteEn),
        .rspValid(zRspValid), .rspReady(zRspReady), .rspRdata(zRspRdata), .rspError(zRspError)
    );

    function automatic logic expErr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // Drives one transaction on dut, pushes the model's expectation, and reports what it saw.
    task automatic sendReq(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int hold,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic stable, output logic readyLow, output logic readyBack);
        expT e;
        logic [31:0] old;
        int n;
        e.err   = expErr(a);
        e.rdata = 32'h0;
        if (!w && !e.err) e.rdata = model.exists(a >> 2) ? model[a >> 2] : 32'hx;
        if (w && !e.err) begin
            old = model.exists(a >> 2) ? model[a >> 2] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
            model[a >> 2] = old;
        end
        sb.push_back(e);
        rd = 32'hx; er = 1'bx; lat = -1; stable = 1'b0; readyLow = 1'b0; readyBack = 1'b0;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d; reqByteEn = be;
        rspReady = 1'b0;
        n = 0;
        while (!reqReady && n < 20) begin @(negedge clk); n++; end
        if (!reqReady) begin reqValid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; reqWrite = ~w; reqAddr = $urandom; reqWdata = $urandom; reqByteEn = 4'hF;
        n = 1;
        readyLow = 1'b1;
        while (!rspValid && n < 20) begin
            if (reqReady) readyLow = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!rspValid) return;
        lat = n;
        if (reqReady) readyLow = 1'b0;
        rd = rspRdata; er = rspError; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rspValid || rspRdata !== rd || rspError !== er) stable = 1'b0;
            if (reqReady) readyLow = 1'b0;
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        readyBack = reqReady && !rspValid;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        reqValid = 0; reqWrite = 0; reqAddr = 0; reqWdata = 0; reqByteEn = 0; rspReady = 0;
        zReqValid = 0; zReqWrite = 0; zReqAddr = 0; zReqWdata = 0; zReqByteEn = 0; zRspReady = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (reqReady !== 1'b0) begin miscompares++; $display("FAIL reset_reqReady got %b want 0", reqReady); end
        vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
        vectors++; if (rspRdata !== 32'h0) begin miscompares++; $display("FAIL reset_rspRdata got %h want 0", rspRdata); end
        vectors++; if (rspError !== 1'b0) begin miscompares++; $display("FAIL reset_rspError got %b want 0", rspError); end
        rst_n = 1'b1;
        #1;
        vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL reset_release_reqReady got %b want 1", reqReady); end
    endtask

    task automatic test_store_load();
        logic ws [2]; logic [31:0] as [2]; logic [31:0] ds [2]; logic [3:0] bes [2];
        logic [31:0] rd; logic er, st, rl, rb; int lat; expT e;
        ws = '{1'b1, 1'b0}; as = '{32'h10, 32'h10}; ds = '{32'hDEADBEEF, 32'h0}; bes = '{4'hF, 4'h0};
        for (int i = 0; i < 2; i++) begin
            sendReq(ws[i], as[i], ds[i], bes[i], 0, rd, er, lat, st, rl, rb);
            e = sb.pop_front();
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL store_load[%0d] rdata got %h want %h", i, rd, e.rdata); end
            vectors++; if (er !== e.err) begin miscompares++; $display("FAIL store_load[%0d] error got %b want %b", i, er, e.err); end
            vectors++; if (lat != WAIT_CYCLES + 1) begin miscompares++; $display("FAIL store_load[%0d] latency got %0d want %0d", i, lat, WAIT_CYCLES + 1); end
            vectors++; if (rb !== 1'b1) begin miscompares++; $display("FAIL store_load[%0d] reqReady_return got %b want 1", i, rb); end
        end
    endtask

    task automatic test_byte_lanes();
        logic ws [4]; logic [31:0] as [4]; logic [31:0] ds [4]; logic [3:0] bes [4];
        logic [31:0] rd; logic er, st, rl, rb; int lat; expT e;
        ws  = '{1'b1, 1'b0, 1'b1, 1'b0};
        as  = '{32'h10, 32'h10, 32'h10, 32'h10};
        ds  = '{32'h000000AA, 32'h0, 32'hFFFFFFFF, 32'h0};
        bes = '{4'h1, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 4; i++) begin
            sendReq(ws[i], as[i], ds[i], bes[i], 0, rd, er, lat, st, rl, rb);
            e = sb.pop_front();
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL byte_lanes[%0d] rdata got %h want %h", i, rd, e.rdata); end
            vectors++; if (er !== e.err) begin miscompares++; $display("FAIL byte_lanes[%0d] error got %b want %b", i, er, e.err); end
        end
        vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL byte_lanes_final got %h want deadbeaa", rd); end
    endtask

    task automatic test_errors();
        logic ws [6]; logic [31:0] as [6]; logic [31:0] ds [6]; logic [3:0] bes [6];
        logic [31:0] rd; logic er, st, rl, rb; int lat; expT e;
        ws  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        as  = '{32'h0, 32'hFC, 32'h12, 32'h100, 32'hFC, 32'h0};
        ds  = '{32'h01020304, 32'h0BADC0DE, 32'h0, 32'h55555555, 32'h0, 32'h0};
        bes = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
        for (int i = 0; i < 6; i++) begin
            sendReq(ws[i], as[i], ds[i], bes[i], 0, rd, er, lat, st, rl, rb);
            e = sb.pop_front();
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL errors[%0d] rdata got %h want %h", i, rd, e.rdata); end
            vectors++; if (er !== e.err) begin miscompares++; $display("FAIL errors[%0d] error got %b want %b", i, er, e.err); end
            vectors++; if (lat != WAIT_CYCLES + 1) begin miscompares++; $display("FAIL errors[%0d] latency got %0d want %0d", i, lat, WAIT_CYCLES + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er, st, rl, rb; int lat; expT e;
        sendReq(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, rl, rb);
        e = sb.pop_front();
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL backpressure rdata got %h want %h", rd, e.rdata); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL backpressure stable got %b want 1", st); end
        vectors++; if (rl !== 1'b1) begin miscompares++; $display("FAIL backpressure reqReady_low got %b want 1", rl); end
        vectors++; if (rb !== 1'b1) begin miscompares++; $display("FAIL backpressure handshake got %b want 1", rb); end
    endtask

    task automatic test_zero_wait();
        logic ws [5]; logic [31:0] as [5]; logic [31:0] ds [5]; logic [31:0] xs [5]; logic xe [5];
        int n, acc, lastAcc;
        expT e, p;
        ws = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        as = '{32'h8, 32'hC, 32'h8, 32'hC, 32'h6};
        ds = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0};
        xs = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0};
        xe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        lastAcc = 0;
        zRspReady = 1'b1;
        @(negedge clk);
        zReqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            zReqWrite = ws[i]; zReqAddr = as[i]; zReqWdata = ds[i]; zReqByteEn = 4'hF;
            n = 0;
            while (!zReqReady && n < 10) begin @(negedge clk); n++; end
            acc = cyc;
            if (i > 0) begin
                vectors++; if (acc - lastAcc != 2) begin miscompares++; $display("FAIL zero_wait[%0d] spacing got %0d want 2", i, acc - lastAcc); end
            end
            lastAcc = acc;
            p.rdata = xs[i]; p.err = xe[i];
            sb.push_back(p);
            @(negedge clk);
            e = sb.pop_front();
            vectors++; if (zRspValid !== 1'b1) begin miscompares++; $display("FAIL zero_wait[%0d] rspValid got %b want 1", i, zRspValid); end
            vectors++; if (zRspRdata !== e.rdata) begin miscompares++; $display("FAIL zero_wait[%0d] rdata got %h want %h", i, zRspRdata, e.rdata); end
            vectors++; if (zRspError !== e.err) begin miscompares++; $display("FAIL zero_wait[%0d] error got %b want %b", i, zRspError, e.err); end
        end
        zReqValid = 1'b0;
        zRspReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, st, rl, rb; int lat, n; expT e;
        sendReq(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, rl, rb);
        e = sb.pop_front();
        vectors++; if (er !== e.err) begin miscompares++; $display("FAIL reset_mid_store error got %b want %b", er, e.err); end
        sendReq(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
        e = sb.pop_front();
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL reset_mid_preload rdata got %h want %h", rd, e.rdata); end
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20; reqWdata = 32'hCAFEF00D; reqByteEn = 4'hF;
        n = 0;
        while (!reqReady && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        vectors++; if ({reqReady, rspValid} !== 2'b00) begin miscompares++; $display("FAIL reset_mid_wait got %b want 00", {reqReady, rspValid}); end
        rst_n = 1'b0;
        #1;
        vectors++; if (reqReady !== 1'b0) begin miscompares++; $display("FAIL reset_mid_reqReady got %b want 0", reqReady); end
        vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_rspValid got %b want 0", rspValid); end
        vectors++; if (rspRdata !== 32'h0) begin miscompares++; $display("FAIL reset_mid_rspRdata got %h want 0", rspRdata); end
        vectors++; if (rspError !== 1'b0) begin miscompares++; $display("FAIL reset_mid_rspError got %b want 0", rspError); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL reset_mid_release got %b want 1", reqReady); end
        sendReq(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
        e = sb.pop_front();
        vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL reset_mid_load rdata got %h want %h", rd, e.rdata); end
        vectors++; if (rd !== 32'h11223344) begin miscompares++; $display("FAIL reset_mid_unchanged got %h want 11223344", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_zero_wait();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
